// File: rtl/alu_uart_sequencer.sv
// Byte-stream front end for the lab ALU: loads A/B/opcode through the switch bus
// and strobes, then returns result/carry on a valid/ready port. Mid-frame timeout under ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
    parameter int unsigned BUS_SIZE       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [BUS_SIZE-1:0] i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_rx_ready,
    output logic [BUS_SIZE-1:0] o_swiches,
    output logic                o_boton1,
    output logic                o_boton2,
    output logic                o_boton3,
    input  logic [BUS_SIZE-1:0] i_alu_result,
    input  logic                i_alu_carry,
    output logic [BUS_SIZE-1:0] o_tx_data,
    output logic                o_tx_carry,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_error
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        LOAD,
        CAPTURE,
        SEND
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [BUS_SIZE-1:0] swiches_d;
    logic                boton1_d;
    logic                boton2_d;
    logic                boton3_d;
    logic [BUS_SIZE-1:0] tx_data_d;
    logic                tx_carry_d;
    logic                tx_valid_d;
    logic                accept;

    // A zero timeout would abort every frame the cycle after its first byte.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign o_rx_ready = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    assign accept     = i_rx_valid && o_rx_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_d;
    logic             timeout;

    // Idle-cycle counter for a partially received frame; any accept or state change clears it.
    always_comb begin
        tmo_cnt_d = '0;
        timeout   = 1'b0;
        if ((state == GET_B || state == GET_OP) && !accept) begin
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt <= '0;
            o_error <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_d;
            o_error <= timeout;
        end
    end
`else
    assign o_error = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= GET_A;
            o_swiches  <= '0;
            o_boton1   <= 1'b0;
            o_boton2   <= 1'b0;
            o_boton3   <= 1'b0;
            o_tx_data  <= '0;
            o_tx_carry <= 1'b0;
            o_tx_valid <= 1'b0;
        end else begin
            state      <= state_d;
            o_swiches  <= swiches_d;
            o_boton1   <= boton1_d;
            o_boton2   <= boton2_d;
            o_boton3   <= boton3_d;
            o_tx_data  <= tx_data_d;
            o_tx_carry <= tx_carry_d;
            o_tx_valid <= tx_valid_d;
        end
    end

    // Next state and next output values; strobes default low so each lasts one cycle.
    always_comb begin
        state_d    = state;
        swiches_d  = o_swiches;
        boton1_d   = 1'b0;
        boton2_d   = 1'b0;
        boton3_d   = 1'b0;
        tx_data_d  = o_tx_data;
        tx_carry_d = o_tx_carry;
        tx_valid_d = o_tx_valid;

        unique case (state)
            GET_A: begin
                if (accept) begin
                    swiches_d = i_rx_data;
                    boton1_d  = 1'b1;
                    state_d   = GET_B;
                end
            end
            GET_B: begin
                if (accept) begin
                    swiches_d = i_rx_data;
                    boton2_d  = 1'b1;
                    state_d   = GET_OP;
                end
            end
            GET_OP: begin
                if (accept) begin
                    swiches_d = i_rx_data;
                    boton3_d  = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                tx_data_d  = i_alu_result;
                tx_carry_d = i_alu_carry;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase

`ifdef ALU_SEQ_TIMEOUT_EN
        if (timeout) begin
            state_d = GET_A;
        end
`endif
    end

endmodule
